// File: rtl/spi_eep_pkg.sv
// Shared types and constants for the SPI calibration-EEPROM responder.
//   op_e       : frame opcode, cmd[15:14]
//   state_e    : responder FSM states
//   FRAME_BITS : bits in a valid frame
//   *_MSB/*_LSB: field positions inside the 16-bit frame
package spi_eep_pkg;

  typedef enum logic [1:0] {
    OP_RD   = 2'b00,
    OP_WR   = 2'b01,
    OP_NOP2 = 2'b10,
    OP_NOP3 = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_EXEC  = 2'b10
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int OP_MSB     = 15;
  localparam int OP_LSB     = 14;
  localparam int ADDR_MSB   = 13;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;
  localparam int DATA_LSB   = 0;

endpackage

// File: rtl/spi_eep_slv_sync_edge.sv
// sync_edge: 2-flop synchronizer for an asynchronous pin plus a third flop
// used to detect edges of the synchronized value.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous pin
//   synced     : pin after two flops
//   rise, fall : one-clk pulses on synchronized edges
// RST_VAL is the idle level of the pin so that reset release does not
// fabricate an edge.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic synced,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign synced = sync_q;
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;

endmodule

// File: rtl/spi_eep_slv.sv
// spi_eep_slv: SPI responder modelling a 64x8 calibration EEPROM.
// The SPI pins are oversampled on clk; 16-bit frames {op, addr, wdata} are
// decoded when SS_n rises. READ data is returned in the low byte of the
// following frame on MISO.
//   clk, rst_n     : system clock, async active-low reset
//   SS_n,SCLK,MOSI : asynchronous SPI inputs (mode 0, MSB first)
//   MISO           : serial data out
//   frm_rdy        : one-clk pulse when a valid frame executes
//   frm_cmd        : last valid frame, held until the next
//   frm_err        : one-clk pulse when a frame ends with bit count != 16
//   wp_n           : write protect, active low (only with SPI_EEP_WP_EN)
// Build option: define SPI_EEP_WP_EN to add the wp_n port.
module spi_eep_slv
  import spi_eep_pkg::*;
#(
  parameter int         DEPTH    = 64,
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
`ifdef SPI_EEP_WP_EN
  input  logic        wp_n,
`endif
  output logic        MISO,
  output logic        frm_rdy,
  output logic [15:0] frm_cmd,
  output logic        frm_err
);

  state_e      state, state_nxt;
  logic        ss_sync, ss_rise, ss_fall;
  logic        sclk_sync_unused, sclk_rise, sclk_fall;
  logic        mosi_meta, mosi_sync;
  logic        wp_ok;
  logic        ld_tx, err_det, err_p0, fall_pend;
  logic [4:0]  bit_cnt;
  logic [15:0] rx_shft, tx_shft;
  logic [7:0]  rd_buf;
  logic [7:0]  mem [0:DEPTH-1];
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  op_e         cmd_op;
  logic        addr_ok;

  // ---- pin synchronization ----
  sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d(SS_n),
    .synced(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK),
    .synced(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;
    end
  end

`ifdef SPI_EEP_WP_EN
  logic wp_meta, wp_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_meta <= 1'b1;
      wp_sync <= 1'b1;
    end else begin
      wp_meta <= wp_n;
      wp_sync <= wp_meta;
    end
  end
  assign wp_ok = wp_sync;
`else
  assign wp_ok = 1'b1;
`endif

  assign cmd_op    = op_e'(rx_shft[OP_MSB:OP_LSB]);
  assign cmd_addr  = rx_shft[ADDR_MSB:ADDR_LSB];
  assign cmd_wdata = rx_shft[DATA_MSB:DATA_LSB];
  assign addr_ok   = (int'(cmd_addr) < DEPTH);

  // MISO is driven only while a frame is being shifted
  assign MISO = (state == ST_SHIFT) & tx_shft[15];

  // ---- frame FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_tx     = 1'b0;
    err_det   = 1'b0;
    case (state)
      ST_IDLE: begin
        // fall_pend covers an SS_n fall that landed during EXEC
        if (ss_fall || (fall_pend && !ss_sync)) begin
          ld_tx     = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          if (bit_cnt == 5'(FRAME_BITS)) begin
            state_nxt = ST_EXEC;
          end else begin
            err_det   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_EXEC:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---- shift registers, execution and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_shft   <= '0;
      tx_shft   <= '0;
      rd_buf    <= INIT_VAL;
      frm_rdy   <= 1'b0;
      frm_err   <= 1'b0;
      err_p0    <= 1'b0;
      frm_cmd   <= '0;
      fall_pend <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else begin
      frm_rdy   <= 1'b0;
      // error pulse is delayed one cycle to line up with frm_rdy timing
      err_p0    <= err_det;
      frm_err   <= err_p0;
      fall_pend <= (state == ST_EXEC) && ss_fall;

      if (ld_tx) begin
        tx_shft <= {8'h00, rd_buf};
        bit_cnt <= '0;
      end else if (state == ST_SHIFT) begin
        if (sclk_rise) begin
          rx_shft <= {rx_shft[14:0], mosi_sync};
          if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
        end
        if (sclk_fall) tx_shft <= {tx_shft[14:0], 1'b0};
      end

      if (state == ST_EXEC) begin
        frm_rdy <= 1'b1;
        frm_cmd <= rx_shft;
        case (cmd_op)
          OP_RD:   rd_buf <= addr_ok ? mem[cmd_addr] : 8'hFF;
          OP_WR:   if (addr_ok && wp_ok) mem[cmd_addr] <= cmd_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_eep_slv.sv
// Scoreboard bench for spi_eep_slv: a bench-side model predicts frame
// results; the monitor checks frm_rdy/frm_err events and MISO words.
module tb_spi_eep_slv;
  import spi_eep_pkg::*;

  localparam logic [7:0] INIT_VAL = 8'h00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic MISO, frm_rdy, frm_err;
  logic [15:0] frm_cmd;
`ifdef SPI_EEP_WP_EN
  logic wp_n = 1'b1;
`endif

  spi_eep_slv #(.DEPTH(64), .INIT_VAL(INIT_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
`ifdef SPI_EEP_WP_EN
    .wp_n(wp_n),
`endif
    .MISO(MISO), .frm_rdy(frm_rdy), .frm_cmd(frm_cmd), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_err; logic [15:0] cmd; } ev_t;
  ev_t         ev_q[$];
  logic [15:0] exp_miso_q[$];
  logic [15:0] got_miso_q[$];

  int n_cmp = 0, n_bad = 0, rdy_seen = 0, err_seen = 0;

  // bench model
  logic [7:0]  mem_m [0:63];
  logic [7:0]  rdbuf_m;
  logic [15:0] last_cmd_m;
  bit          wp_m = 1'b1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem_m[i] = INIT_VAL;
    rdbuf_m    = INIT_VAL;
    last_cmd_m = 16'h0000;
  endtask

  // monitor: pops expectations when the DUT presents an event or MISO word
  always @(negedge clk) begin
    if (frm_rdy || frm_err) begin
      if (ev_q.size() == 0) begin
        check(frm_rdy ? "spurious_rdy" : "spurious_err", {15'd0, frm_rdy}, 16'd0);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        check("event_is_err", {15'd0, frm_err}, {15'd0, e.is_err});
        check("event_rdy", {15'd0, frm_rdy}, {15'd0, !e.is_err});
        check("frm_cmd", frm_cmd, e.cmd);
      end
      if (frm_rdy) rdy_seen++;
      if (frm_err) err_seen++;
    end
    while (got_miso_q.size() > 0 && exp_miso_q.size() > 0)
      check("miso_word", got_miso_q.pop_front(), exp_miso_q.pop_front());
  end

  // SPI mode-0 master, SCLK = clk/16
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input bit close,
                           output logic [15:0] got);
    got = '0;
    @(negedge clk) SS_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = cmd[15-i];
      repeat (8) @(negedge clk);
      SCLK = 1'b1;
      got  = {got[14:0], MISO};
      repeat (8) @(negedge clk);
      SCLK = 1'b0;
    end
    if (close) begin
      repeat (4) @(negedge clk);
      SS_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic do_frame(input logic [15:0] cmd, input int nbits);
    logic [15:0] got;
    logic [5:0]  a;
    a = cmd[13:8];
    if (nbits == 16) begin
      exp_miso_q.push_back({8'h00, rdbuf_m});
      ev_q.push_back('{is_err: 1'b0, cmd: cmd});
      case (cmd[15:14])
        2'b00: rdbuf_m = mem_m[a];
        2'b01: if (wp_m) mem_m[a] = cmd[7:0];
        default: ;
      endcase
      last_cmd_m = cmd;
    end else begin
      ev_q.push_back('{is_err: 1'b1, cmd: last_cmd_m});
    end
    spi_frame(cmd, nbits, 1'b1, got);
    if (nbits == 16) got_miso_q.push_back(got);
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
    check("events_drained", 16'(ev_q.size()), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, e0;
    logic [15:0] dummy;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_miso", {15'd0, MISO}, 16'd0);
    check("rst_rdy", {15'd0, frm_rdy}, 16'd0);
    check("rst_err", {15'd0, frm_err}, 16'd0);
    check("rst_cmd", frm_cmd, 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // reset contents
    do_frame(16'h3F00, 16);
    do_frame(16'h8000, 16);
    settle();

    // write then read then nop: NOP MISO = 00A7
    r0 = rdy_seen;
    do_frame(16'h45A7, 16);
    do_frame(16'h0500, 16);
    do_frame(16'h8000, 16);
    settle();
    check("rdy_x3", 16'(rdy_seen - r0), 16'd3);

    // short frame: one error, memory and frm_cmd unchanged
    e0 = err_seen;
    do_frame(16'h4500, 9);
    do_frame(16'h0500, 16);
    do_frame(16'hC000, 16);
    settle();
    check("short_err_x1", 16'(err_seen - e0), 16'd1);

    // write protect
`ifdef SPI_EEP_WP_EN
    wp_n = 1'b0; wp_m = 1'b0;
    repeat (4) @(negedge clk);
    do_frame(16'h5055, 16);
    do_frame(16'h1000, 16);
    do_frame(16'h8000, 16);
    settle();
    wp_n = 1'b1; wp_m = 1'b1;
    repeat (4) @(negedge clk);
`endif
    do_frame(16'h5055, 16);
    do_frame(16'h1000, 16);
    do_frame(16'h8000, 16);
    settle();

    // reset mid-frame: rd_buf = 55 (bit7=0), reload A7 first so MISO is 1
    do_frame(16'h0500, 16);
    settle();
    spi_frame(16'h8000, 8, 1'b0, dummy);
    repeat (4) @(negedge clk);
    check("midframe_miso_pre", {15'd0, MISO}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("midframe_miso_rst", {15'd0, MISO}, 16'd0);
    SS_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("midframe_cmd_rst", frm_cmd, 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_frame(16'h4A3C, 16);
    do_frame(16'h0A00, 16);
    do_frame(16'h8000, 16);
    settle();

    // back-to-back random stress
    e0 = err_seen;
    for (int i = 0; i < 100; i++) begin
      logic [15:0] c;
      c = {1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255))};
      do_frame(c, 16);
    end
    settle();
    check("stress_no_err", 16'(err_seen - e0), 16'd0);
    check("miso_drained", 16'(exp_miso_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
